// File: rtl/seven_segment_scanner_if.sv
// Load handshake between the readout data path and the seven-segment scanner.
// The upstream stage holds loadValue/loadDp while loadValid is high and loadReady is low.
interface seven_segment_scanner_if;
   logic        loadValid;
   logic        loadReady;
   logic [15:0] loadValue;
   logic [3:0]  loadDp;

   modport master (
      output loadValid,
      output loadValue,
      output loadDp,
      input  loadReady
   );

   modport slave (
      input  loadValid,
      input  loadValue,
      input  loadDp,
      output loadReady
   );
endinterface

// File: rtl/seven_segment_scanner.sv
// Scans a 16-bit hex value onto a 4-digit common-anode display, one digit per REFRESH_COUNT
// cycles. New values wait in a one-deep pending register and are applied only at frame ends.
module seven_segment_scanner #(
   parameter int unsigned REFRESH_COUNT = 100000,
   parameter int unsigned COUNTER_WIDTH = 17
) (
   input  logic                          cmosClock,
   input  logic                          reset,
   seven_segment_scanner_if.slave        loadBus,
   input  logic                          leadingZeroBlank,
   output logic [3:0]                    sevenSegmentEnable,
   output logic [7:0]                    sevenSegmentData
);

   localparam logic [COUNTER_WIDTH-1:0] LastCount = COUNTER_WIDTH'(REFRESH_COUNT - 1);

   logic [COUNTER_WIDTH-1:0] prescaler;
   logic [1:0]               digitIndex;
   logic [15:0]              shownValue;
   logic [3:0]               shownDp;
   logic [15:0]              pendingValue;
   logic [3:0]               pendingDp;
   logic                     pendingFull;

   logic       tick;
   logic       frameEnd;
   logic       accept;
   logic [3:0] nibble;
   logic       blank;
   logic [3:0] enableNext;
   logic [7:0] dataNext;

   // Active-low segment pattern {g,f,e,d,c,b,a} for one hex digit.
   function automatic logic [6:0] hexSegments(input logic [3:0] value);
      logic [6:0] seg;
      unique case (value)
         4'h0: seg = 7'h40;
         4'h1: seg = 7'h79;
         4'h2: seg = 7'h24;
         4'h3: seg = 7'h30;
         4'h4: seg = 7'h19;
         4'h5: seg = 7'h12;
         4'h6: seg = 7'h02;
         4'h7: seg = 7'h78;
         4'h8: seg = 7'h00;
         4'h9: seg = 7'h10;
         4'hA: seg = 7'h08;
         4'hB: seg = 7'h03;
         4'hC: seg = 7'h46;
         4'hD: seg = 7'h21;
         4'hE: seg = 7'h06;
         4'hF: seg = 7'h0E;
      endcase
      return seg;
   endfunction

   assign loadBus.loadReady = !pendingFull;

   always_comb begin
      tick       = (prescaler == LastCount);
      frameEnd   = tick && (digitIndex == 2'd3);
      accept     = loadBus.loadValid && !pendingFull;
      nibble     = shownValue[{digitIndex, 2'b00} +: 4];
      blank      = 1'b0;
      // A digit is a leading zero only if it and every more-significant nibble are zero.
      unique case (digitIndex)
         2'd3: blank = (shownValue[15:12] == 4'h0);
         2'd2: blank = (shownValue[15:8] == 8'h00);
         2'd1: blank = (shownValue[15:4] == 12'h000);
         2'd0: blank = 1'b0;
      endcase
      blank      = blank && leadingZeroBlank;
      enableNext = ~(4'b0001 << digitIndex);
      dataNext   = {!shownDp[digitIndex], blank ? 7'h7F : hexSegments(nibble)};
   end

   always_ff @(posedge cmosClock) begin
      if (reset) begin
         prescaler          <= '0;
         digitIndex         <= 2'd0;
         shownValue         <= 16'h0000;
         shownDp            <= 4'h0;
         pendingValue       <= 16'h0000;
         pendingDp          <= 4'h0;
         pendingFull        <= 1'b0;
         sevenSegmentEnable <= 4'b1111;
         sevenSegmentData   <= 8'hFF;
      end else begin
         prescaler <= tick ? '0 : prescaler + COUNTER_WIDTH'(1);
         if (tick) begin
            digitIndex <= digitIndex + 2'd1;
         end
         // accept needs an empty pending slot, so it never collides with the transfer.
         if (accept) begin
            pendingValue <= loadBus.loadValue;
            pendingDp    <= loadBus.loadDp;
            pendingFull  <= 1'b1;
         end else if (frameEnd && pendingFull) begin
            shownValue  <= pendingValue;
            shownDp     <= pendingDp;
            pendingFull <= 1'b0;
         end
         sevenSegmentEnable <= enableNext;
         sevenSegmentData   <= dataNext;
      end
   end

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Directed bench for seven_segment_scanner with REFRESH_COUNT=4; t counts edges since reset release.
module tb_seven_segment_scanner;

   logic       cmosClock;
   logic       reset;
   logic       leadingZeroBlank;
   logic [3:0] sevenSegmentEnable;
   logic [7:0] sevenSegmentData;
   int         t;
   int         passCount;
   int         checkCount;

   seven_segment_scanner_if loadBus ();

   seven_segment_scanner #(
      .REFRESH_COUNT(4),
      .COUNTER_WIDTH(3)
   ) dut (
      .cmosClock         (cmosClock),
      .reset             (reset),
      .loadBus           (loadBus.slave),
      .leadingZeroBlank  (leadingZeroBlank),
      .sevenSegmentEnable(sevenSegmentEnable),
      .sevenSegmentData  (sevenSegmentData)
   );

   initial begin
      cmosClock = 1'b0;
      forever #5 cmosClock = ~cmosClock;
   end

   task automatic step();
      @(posedge cmosClock);
      #1;
      t++;
   endtask

   task automatic stepTo(input int target);
      while (t < target) step();
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checkCount++;
      assert (obs === exp) passCount++;
      else $error("FAIL %s t=%0d observed=%h expected=%h", tag, t, obs, exp);
   endtask

   task automatic chkDigit(input string tag, input logic [3:0] expEnable, input logic [7:0] expData);
      chk({tag, ".enable"}, {12'h0, sevenSegmentEnable}, {12'h0, expEnable});
      chk({tag, ".data"}, {8'h0, sevenSegmentData}, {8'h0, expData});
   endtask

   task automatic chkReady(input string tag, input logic exp);
      chk(tag, {15'h0, loadBus.loadReady}, {15'h0, exp});
   endtask

   initial begin
      logic [3:0] walk;
      t                 = 0;
      passCount         = 0;
      checkCount        = 0;
      reset             = 1'b1;
      leadingZeroBlank  = 1'b0;
      loadBus.loadValid = 1'b0;
      loadBus.loadValue = 16'h0000;
      loadBus.loadDp    = 4'h0;
      step();
      step();
      chkDigit("reset", 4'b1111, 8'hFF);
      chkReady("resetReady", 1'b1);
      reset = 1'b0;
      t     = 0;

      // Idle scan: anode walks every 4 cycles, value 0000 shows C0 everywhere.
      for (int i = 1; i <= 32; i++) begin
         step();
         walk = 4'b1111 ^ (4'b0001 << (((t - 1) / 4) % 4));
         chkDigit("idleWalk", walk, 8'hC0);
      end

      // Mid-frame load of 1A3F with dp on digit 2.
      loadBus.loadValid = 1'b1;
      loadBus.loadValue = 16'h1A3F;
      loadBus.loadDp    = 4'b0100;
      step();
      chkReady("loadReadyDrop", 1'b0);
      loadBus.loadValid = 1'b0;
      stepTo(40);
      chkDigit("oldHeld", 4'b1101, 8'hC0);
      stepTo(47);
      chkReady("pendingHeld", 1'b0);
      step();
      chkReady("readyAfterXfer", 1'b1);
      chkDigit("lastOldDigit", 4'b0111, 8'hC0);
      step();
      chkDigit("new0", 4'b1110, 8'h8E);
      stepTo(53);
      chkDigit("new1", 4'b1101, 8'hB0);
      stepTo(57);
      chkDigit("new2dp", 4'b1011, 8'h08);
      stepTo(61);
      chkDigit("new3", 4'b0111, 8'hF9);

      // Back-to-back loads: second waits until the first transfers.
      stepTo(64);
      loadBus.loadValid = 1'b1;
      loadBus.loadValue = 16'h0001;
      loadBus.loadDp    = 4'h0;
      step();
      chkReady("b2bFirstTaken", 1'b0);
      loadBus.loadValue = 16'h0002;
      stepTo(79);
      chkReady("b2bStall", 1'b0);
      step();
      chkReady("b2bReadyAgain", 1'b1);
      step();
      chkReady("b2bSecondTaken", 1'b0);
      chkDigit("b2bShow1", 4'b1110, 8'hF9);
      loadBus.loadValid = 1'b0;
      stepTo(85);
      chkDigit("b2bShow1d1", 4'b1101, 8'hC0);
      stepTo(97);
      chkDigit("b2bShow2", 4'b1110, 8'hA4);

      // Leading-zero blanking, applied live then on 0050 and 0000.
      stepTo(101);
      chkDigit("noBlank", 4'b1101, 8'hC0);
      leadingZeroBlank  = 1'b1;
      loadBus.loadValid = 1'b1;
      loadBus.loadValue = 16'h0050;
      step();
      chkReady("lzbLoadTaken", 1'b0);
      loadBus.loadValid = 1'b0;
      stepTo(105);
      chkDigit("liveBlank2", 4'b1011, 8'hFF);
      stepTo(109);
      chkDigit("liveBlank3", 4'b0111, 8'hFF);
      stepTo(113);
      chkDigit("lzb50d0", 4'b1110, 8'hC0);
      stepTo(117);
      chkDigit("lzb50d1", 4'b1101, 8'h92);
      stepTo(121);
      chkDigit("lzb50d2", 4'b1011, 8'hFF);
      stepTo(125);
      chkDigit("lzb50d3", 4'b0111, 8'hFF);
      loadBus.loadValid = 1'b1;
      loadBus.loadValue = 16'h0000;
      step();
      loadBus.loadValid = 1'b0;
      stepTo(129);
      chkDigit("lzb0d0", 4'b1110, 8'hC0);
      stepTo(133);
      chkDigit("lzb0d1", 4'b1101, 8'hFF);
      stepTo(137);
      chkDigit("lzb0d2", 4'b1011, 8'hFF);
      stepTo(141);
      chkDigit("lzb0d3", 4'b0111, 8'hFF);
      leadingZeroBlank = 1'b0;
      stepTo(149);
      chkDigit("lzbOff", 4'b1101, 8'hC0);

      // Accept on the frameEnd cycle: no bypass, shown one frame later.
      stepTo(159);
      loadBus.loadValid = 1'b1;
      loadBus.loadValue = 16'h1234;
      step();
      chkReady("frameEndAccept", 1'b0);
      loadBus.loadValid = 1'b0;
      step();
      chkDigit("noBypass0", 4'b1110, 8'hC0);
      stepTo(165);
      chkDigit("noBypass1", 4'b1101, 8'hC0);
      stepTo(177);
      chkDigit("late0", 4'b1110, 8'h99);
      stepTo(181);
      chkDigit("late1", 4'b1101, 8'hB0);

      // Reset with pending full mid-scan discards the pending value.
      stepTo(185);
      loadBus.loadValid = 1'b1;
      loadBus.loadValue = 16'h8888;
      step();
      chkReady("preResetFull", 1'b0);
      loadBus.loadValid = 1'b0;
      stepTo(190);
      reset = 1'b1;
      step();
      chkDigit("midReset", 4'b1111, 8'hFF);
      chkReady("midResetReady", 1'b1);
      reset = 1'b0;
      t     = 0;
      step();
      chkDigit("postReset0", 4'b1110, 8'hC0);
      stepTo(17);
      chkDigit("discarded0", 4'b1110, 8'hC0);
      stepTo(29);
      chkDigit("discarded3", 4'b0111, 8'hC0);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
